// File: rtl/button_event_unit.sv
// button_event_unit: turns the debouncer's validated sample stream
// (count_finished strobe + db_signal level) into press / release /
// long-press / auto-repeat pulses, a held level and a wrapping press count.
// Optional feature macro: AUTO_REPEAT_EN (repeat counter and repeat_pulse).
// Without it, repeat_pulse is tied low and LONG simply waits for release.
// dbg_state exposes the FSM state (0=IDLE, 1=PRESSED, 2=LONG).
//
// Handshake: count_finished is a one-cycle sample-valid strobe with no
// back-pressure; every clock with count_finished=1 is consumed as a sample,
// db_signal is ignored otherwise, and one sample per clock is accepted.
module button_event_unit #(
   parameter int LONG_SAMPLES   = 16,
   parameter int REPEAT_SAMPLES = 4,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       count_finished,
   input  logic       db_signal,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_press_pulse,
   output logic       repeat_pulse,
   output logic [7:0] press_count,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_SAMPLES);

   // Elaboration-time guard on the legal counter ranges
   if (LONG_SAMPLES < 1 || LONG_SAMPLES > (2**CNT_W) - 1 ||
       REPEAT_SAMPLES < 1 || REPEAT_SAMPLES > (2**CNT_W) - 1) begin : g_param_check
      $error("button_event_unit: LONG_SAMPLES/REPEAT_SAMPLES out of range for CNT_W");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] w_hold_nxt;
   logic [CNT_W-1:0] w_hold_inc;
   logic             w_hold_hit;

   logic             r_btn_level;
   logic             r_press;
   logic             r_release;
   logic             r_long;
   logic [7:0]       r_press_count;

   logic             w_level_nxt;
   logic             w_press_nxt;
   logic             w_release_nxt;
   logic             w_long_nxt;
   logic [7:0]       w_count_nxt;

   assign w_hold_inc = r_hold_cnt + 1'b1;
   assign w_hold_hit = (w_hold_inc == LONG_C);

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_C = CNT_W'(REPEAT_SAMPLES);

   logic [CNT_W-1:0] r_rep_cnt;
   logic [CNT_W-1:0] w_rep_nxt;
   logic [CNT_W-1:0] w_rep_inc;
   logic             w_rep_hit;
   logic             r_repeat;
   logic             w_repeat_nxt;

   assign w_rep_inc = r_rep_cnt + 1'b1;
   assign w_rep_hit = (w_rep_inc == REP_C);

   // Repeat counter: counts high samples in LONG, cleared on entry and on release
   always_comb begin
      w_rep_nxt    = r_rep_cnt;
      w_repeat_nxt = 1'b0;
      if (count_finished) begin
         if (!db_signal) begin
            w_rep_nxt = '0;
         end else if (r_state == ST_LONG) begin
            if (w_rep_hit) begin
               w_rep_nxt    = '0;
               w_repeat_nxt = 1'b1;
            end else begin
               w_rep_nxt = w_rep_inc;
            end
         end else if (r_state == ST_PRESSED && w_hold_hit) begin
            w_rep_nxt = '0;
         end else if (r_state == ST_IDLE) begin
            w_rep_nxt = '0;
         end
      end
   end

   // Repeat counter and pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rep_cnt <= '0;
         r_repeat  <= 1'b0;
      end else begin
         r_rep_cnt <= w_rep_nxt;
         r_repeat  <= w_repeat_nxt;
      end
   end

   assign repeat_pulse = r_repeat;
`else
   assign repeat_pulse = 1'b0;
`endif

   // State register plus hold counter and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_hold_cnt    <= '0;
         r_btn_level   <= 1'b0;
         r_press       <= 1'b0;
         r_release     <= 1'b0;
         r_long        <= 1'b0;
         r_press_count <= 8'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_hold_cnt    <= w_hold_nxt;
         r_btn_level   <= w_level_nxt;
         r_press       <= w_press_nxt;
         r_release     <= w_release_nxt;
         r_long        <= w_long_nxt;
         r_press_count <= w_count_nxt;
      end
   end

   // Next-state and hold counter; non-sample cycles hold everything
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      if (count_finished) begin
         case (r_state)
            ST_IDLE: begin
               if (db_signal) begin
                  w_hold_nxt  = CNT_W'(1);
                  w_state_nxt = (LONG_SAMPLES == 1) ? ST_LONG : ST_PRESSED;
               end
            end
            ST_PRESSED: begin
               if (db_signal) begin
                  w_hold_nxt = w_hold_inc;
                  if (w_hold_hit) w_state_nxt = ST_LONG;
               end else begin
                  w_hold_nxt  = '0;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_LONG: begin
               // hold_cnt stays saturated at LONG_SAMPLES while in LONG
               if (!db_signal) begin
                  w_hold_nxt  = '0;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: begin
               w_hold_nxt  = '0;
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Output decode: pulses default low, level and count hold between samples
   always_comb begin
      w_level_nxt   = r_btn_level;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_long_nxt    = 1'b0;
      w_count_nxt   = r_press_count;
      if (count_finished) begin
         case (r_state)
            ST_IDLE: begin
               if (db_signal) begin
                  w_press_nxt = 1'b1;
                  w_level_nxt = 1'b1;
                  w_count_nxt = r_press_count + 8'd1;
                  w_long_nxt  = (LONG_SAMPLES == 1);
               end
            end
            ST_PRESSED: begin
               if (db_signal) begin
                  w_long_nxt = w_hold_hit;
               end else begin
                  w_release_nxt = 1'b1;
                  w_level_nxt   = 1'b0;
               end
            end
            ST_LONG: begin
               if (!db_signal) begin
                  w_release_nxt = 1'b1;
                  w_level_nxt   = 1'b0;
               end
            end
            default: begin
               w_level_nxt = 1'b0;
            end
         endcase
      end
   end

   assign btn_level        = r_btn_level;
   assign press_pulse      = r_press;
   assign release_pulse    = r_release;
   assign long_press_pulse = r_long;
   assign press_count      = r_press_count;
   assign dbg_state        = r_state;

endmodule

// File: doc/button_event_unit.md
Name: button_event_unit

Overview:
Downstream consumer of the debounce stage. Takes the debouncer's validated sample strobe (count_finished) and sampled level (db_signal), and turns the stream of stable samples into clean button events: press, release, long-press and auto-repeat. Also produces a held level and a wrapping press counter. Sits between the debounce chain and the control FSMs that react to the user buttons.

Parameters:
LONG_SAMPLES, 16, consecutive high samples (press sample included) before long_press fires; legal range 1..2^CNT_W-1
REPEAT_SAMPLES, 4, high samples between repeat pulses once in LONG state; legal range 1..2^CNT_W-1
CNT_W, 8, width of the internal hold/repeat counters

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
count_finished  input  1  sample-valid strobe from debounce, 1 cycle wide
db_signal  input  1  stable sampled level; meaningful only when count_finished=1
btn_level  output  1  registered debounced level (last valid sample)
press_pulse  output  1  1-cycle pulse on 0->1 sample transition
release_pulse  output  1  1-cycle pulse on 1->0 sample transition
long_press_pulse  output  1  1-cycle pulse when hold reaches LONG_SAMPLES
repeat_pulse  output  1  1-cycle pulse every REPEAT_SAMPLES high samples in LONG state (AUTO_REPEAT_EN only)
press_count  output  8  number of presses, wraps 255->0

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, hold_cnt=0, rep_cnt=0; all outputs 0, press_count=0.
- Only cycles with count_finished=1 are samples. db_signal with count_finished=0 is ignored and state holds.
- All outputs are registered. A pulse is high for exactly the one cycle after the sampling edge. Pulses default to 0 on every other cycle.
- States: IDLE (level 0), PRESSED (level 1, hold < LONG_SAMPLES), LONG (level 1, long press already reported).
- IDLE, sample=1: press_pulse=1; btn_level=1; press_count+1; hold_cnt=1. If LONG_SAMPLES==1, long_press_pulse=1 in the same cycle, rep_cnt=0, go to LONG. Otherwise go to PRESSED.
- IDLE, sample=0: no change.
- PRESSED, sample=1: hold_cnt+1. When the new hold_cnt == LONG_SAMPLES: long_press_pulse=1, rep_cnt=0, go to LONG.
- PRESSED/LONG, sample=0: release_pulse=1; btn_level=0; hold_cnt=0; rep_cnt=0; go to IDLE. No long or repeat pulse is generated on the release sample.
- LONG, sample=1: rep_cnt+1. When rep_cnt reaches REPEAT_SAMPLES: repeat_pulse=1 and rep_cnt=0. hold_cnt saturates at LONG_SAMPLES and never wraps.
- At most one of press/release fires per sample. long_press may coincide with press only when LONG_SAMPLES==1.
- Back-to-back strobes on consecutive cycles are each processed; the block accepts one sample per clock.
- Reset mid-press: immediate return to IDLE, no release_pulse emitted, press_count cleared.
- press_count is 8-bit modular: 255 + press -> 0.

Optional Feature:
Macro AUTO_REPEAT_EN.
- Defined: rep_cnt and repeat_pulse logic present, as described above.
- Undefined: rep_cnt is removed, repeat_pulse is tied to 0, and LONG only waits for release.

Test Plan:
- Reset asserted mid-LONG with press_count=5 -> all outputs 0 within the same cycle (async); press_count=0; next high sample gives press_pulse.
- Strobes with db_signal=1,1,1,0 (LONG_SAMPLES=16) -> press_pulse after the 1st, release_pulse after the 4th, no long_press; press_count=1.
- 16 consecutive high samples, then 9 more (REPEAT_SAMPLES=4, AUTO_REPEAT_EN) -> long_press after sample 16; repeat_pulse after samples 20 and 24; release on next 0 sample.
- db_signal toggling with count_finished=0 for 100 cycles -> no pulses, btn_level unchanged.
- LONG_SAMPLES=1, single high sample -> press_pulse and long_press_pulse both high in the same cycle.
- 256 press/release cycles -> press_count wraps to 0; strobes on consecutive clocks all counted.
